keypad_lock_ctrl: RTL and testbench
===================================

Name: keypad_lock_ctrl

Overview:
- Synchronous, parametrised successor to the discrete keypad-lock datapath (encoder, T-FF clocked digit registers, comparator, attempt counter, alarm D-FF).
- Collapses that datapath into one clocked controller: N-digit BCD entry buffer, stored passcode, comparison, attempt limiting, timed lockout/alarm, auto-relock and in-field passcode reprogramming.
- Sits between the keypad encoder (BCD key pulses) and the 7-segment display and actuator outputs.

Parameters:
- DIGITS, 8, number of BCD digits in the passcode (1..8).
- DEFAULT_CODE, 32'h12345678, reset passcode; low 4*DIGITS bits used, digit 0 (first entered) in the most significant nibble.
- MAX_ATTEMPTS, 3, consecutive failures that trigger the alarm (1..15).
- LOCKOUT_CYCLES, 1000, minimum alarm duration in clocks (>=1).
- RELOCK_CYCLES, 5000, unlocked timeout in clocks (0 disables auto-relock).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-low; sampled on rising clk.
- key_valid  in  1  one-cycle key strobe.
- key_code  in  4  BCD digit, qualified by key_valid.
- enter_key  in  1  one-cycle submit strobe.
- clear_key  in  1  one-cycle cancel strobe.
- lock_cmd  in  1  one-cycle relock request.
- program_en  in  1  one-cycle request to enter PROGRAM (honoured only in UNLOCKED).
- alarm_reset  in  1  one-cycle alarm acknowledge.
- unlocked  out  1  high in UNLOCKED and PROGRAM.
- alarm  out  1  high in ALARM.
- programming  out  1  high in PROGRAM.
- entry_digits  out  4*DIGITS  entry buffer for display, newest digit in low nibble.
- entry_count  out  4  digits currently buffered (0..DIGITS).
- attempts  out  4  consecutive failed checks.
- fail_pulse  out  1  one-cycle pulse on a failed check.
- code_written  out  1  one-cycle pulse when a new passcode is stored.

Behaviour:
- All state is registered; every output is a register or a decode of the state register.

Reset (rst=0 at a clk edge):
- State=ENTRY; passcode=DEFAULT_CODE; buffer, entry_count and attempts = 0.
- Timers = 0; all outputs 0.
- Reset wins over every input, in every state, including mid-lockout and mid-program.

States:
- ENTRY, CHECK, UNLOCKED, PROGRAM, ALARM.

Input priority within one cycle:
- clear_key > enter_key > key_valid.
- A lower-priority strobe in the same cycle is dropped.

Digit capture (ENTRY and PROGRAM):
- key_valid with key_code<=9 and entry_count<DIGITS: buffer <= {buffer[4*DIGITS-5:0], key_code}; entry_count+1.
- key_code>9 is ignored.
- Keys arriving when entry_count==DIGITS are ignored; there is no wrap and no overwrite.

clear_key (ENTRY and PROGRAM):
- Buffer and entry_count cleared; attempts unchanged.
- In PROGRAM, clear_key also aborts to UNLOCKED and the passcode is unchanged.

ENTRY:
- enter_key with entry_count==0 is ignored.
- enter_key with entry_count>0 -> CHECK.

CHECK (exactly one cycle):
- Match requires entry_count==DIGITS and buffer==passcode.
- Match -> UNLOCKED; attempts=0.
- Mismatch, including a partial entry -> fail_pulse=1; attempts+1.
- Mismatch with the new attempts count ==MAX_ATTEMPTS -> ALARM and lockout timer loaded; otherwise -> ENTRY.
- Buffer and entry_count cleared on exit in all cases.

Latency:
- enter_key sampled at edge k, state=CHECK after edge k.
- unlocked, or fail_pulse, registered high after edge k+1.

UNLOCKED:
- Relock timer counts up.
- lock_cmd, or timer==RELOCK_CYCLES-1 with RELOCK_CYCLES>0, -> ENTRY with timer cleared.
- program_en -> PROGRAM with buffer cleared.
- Key, enter and clear strobes are ignored.
- lock_cmd wins over program_en when both arrive in the same cycle.

PROGRAM:
- Relock timer is frozen; lock_cmd is ignored.
- enter_key with entry_count==DIGITS: passcode <= buffer; code_written=1; -> UNLOCKED; relock timer restarted.
- enter_key with entry_count<DIGITS is ignored.

ALARM:
- All keypad strobes are ignored.
- Lockout down-counter starts at LOCKOUT_CYCLES-1 and saturates at 0.
- alarm_reset is honoured only when the counter==0 -> ENTRY with attempts=0.
- alarm_reset before expiry is discarded and is not remembered.

Widths:
- attempts is 4 bits and compares exactly with MAX_ATTEMPTS; it cannot exceed MAX_ATTEMPTS.
- Timer widths are $clog2(max(LOCKOUT_CYCLES, RELOCK_CYCLES)+1).

Test Plan:
- (Bench parameters: DIGITS=4, DEFAULT_CODE=16'h1234, MAX_ATTEMPTS=3, LOCKOUT_CYCLES=8, RELOCK_CYCLES=16.)
- Reset then keys 1,2,3,4, enter -> entry_digits=16'h1234 and entry_count=4 before enter; unlocked=1 exactly 2 edges after enter; attempts=0.
- Keys 1,2,3,5 enter; then keys 9 enter; then keys 0,0,0,0 enter -> fail_pulse three times; attempts 1,2; alarm=1 after the third CHECK; alarm_reset at lockout cycle 3 ignored; alarm_reset after 8 cycles -> ENTRY, attempts=0.
- Keys 1,2,3,4,5 (5th ignored), key_code=4'hA ignored, key_valid+enter_key in the same cycle -> key dropped, CHECK entered, unlock succeeds with 16'h1234.
- Unlock, program_en, keys 9,8,7,6, enter -> code_written pulse, unlocked=1; lock_cmd -> ENTRY; 1,2,3,4 fails; 9,8,7,6 unlocks.
- Unlock, idle 16 cycles -> unlocked falls on the 16th cycle; PROGRAM with clear_key -> passcode still 16'h1234.
- rst=0 asserted mid-ALARM and mid-PROGRAM with digits buffered -> after one edge all outputs 0, state ENTRY, passcode=16'h1234.

Source files
------------

// File: rtl/keypad_lock_ctrl.sv
// rtl/keypad_lock_ctrl.sv - keypad lock controller: BCD entry, passcode check, lockout, relock, reprogramming
module keypad_lock_ctrl #(
  parameter int          DIGITS         = 8,
  parameter logic [31:0] DEFAULT_CODE   = 32'h12345678,
  parameter int          MAX_ATTEMPTS   = 3,
  parameter int          LOCKOUT_CYCLES = 1000,
  parameter int          RELOCK_CYCLES  = 5000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  input  logic                enter_key,
  input  logic                clear_key,
  input  logic                lock_cmd,
  input  logic                program_en,
  input  logic                alarm_reset,
  output logic                unlocked,
  output logic                alarm,
  output logic                programming,
  output logic [4*DIGITS-1:0] entry_digits,
  output logic [3:0]          entry_count,
  output logic [3:0]          attempts,
  output logic                fail_pulse,
  output logic                code_written
);

  localparam int W    = 4 * DIGITS;
  localparam int TMAX = (LOCKOUT_CYCLES > RELOCK_CYCLES) ? LOCKOUT_CYCLES : RELOCK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] LOCK_LOAD   = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] RELOCK_LAST = TW'(RELOCK_CYCLES - 1);
  localparam logic [3:0]    FULL        = 4'(DIGITS);
  localparam logic [3:0]    MAX_ATT     = 4'(MAX_ATTEMPTS);
  localparam logic [W-1:0]  RESET_CODE  = DEFAULT_CODE[W-1:0];

  typedef enum logic [2:0] {
    S_ENTRY    = 3'd0,
    S_CHECK    = 3'd1,
    S_UNLOCKED = 3'd2,
    S_PROGRAM  = 3'd3,
    S_ALARM    = 3'd4
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [W-1:0]  buffer;
  logic [W-1:0]  passcode;
  logic [3:0]    count;
  logic [3:0]    attempt_cnt;
  logic [3:0]    attempts_inc;
  logic [TW-1:0] relock_timer;
  logic [TW-1:0] lockout_timer;

  logic do_clear;
  logic do_enter;
  logic do_key;
  logic buf_full;
  logic match;
  logic relock_expire;
  logic lockout_done;

  // Strobe arbitration (clear beats enter beats key) and shared decodes
  always_comb begin
    do_clear      = clear_key;
    do_enter      = enter_key & ~clear_key;
    buf_full      = (count == FULL);
    do_key        = key_valid & ~enter_key & ~clear_key & (key_code <= 4'd9) & ~buf_full;
    match         = buf_full && (buffer == passcode);
    attempts_inc  = attempt_cnt + 4'd1;
    relock_expire = (RELOCK_CYCLES != 0) && (relock_timer == RELOCK_LAST);
    lockout_done  = (lockout_timer == '0);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= S_ENTRY;
    else      state <= state_next;
  end

  // Next-state selection
  always_comb begin
    state_next = state;
    case (state)
      S_ENTRY: begin
        if (do_enter && count != 4'd0) state_next = S_CHECK;
      end
      S_CHECK: begin
        if (match)                        state_next = S_UNLOCKED;
        else if (attempts_inc == MAX_ATT) state_next = S_ALARM;
        else                              state_next = S_ENTRY;
      end
      S_UNLOCKED: begin
        if (lock_cmd || relock_expire) state_next = S_ENTRY;
        else if (program_en)           state_next = S_PROGRAM;
      end
      S_PROGRAM: begin
        if (do_clear)                  state_next = S_UNLOCKED;
        else if (do_enter && buf_full) state_next = S_UNLOCKED;
      end
      S_ALARM: begin
        if (alarm_reset && lockout_done) state_next = S_ENTRY;
      end
      default: state_next = S_ENTRY;
    endcase
  end

  // State-decoded status outputs
  always_comb begin
    unlocked    = 1'b0;
    alarm       = 1'b0;
    programming = 1'b0;
    case (state)
      S_UNLOCKED: unlocked = 1'b1;
      S_PROGRAM: begin
        unlocked    = 1'b1;
        programming = 1'b1;
      end
      S_ALARM:    alarm = 1'b1;
      default:    ;
    endcase
  end

  // Entry buffer, passcode, attempt counter, timers and one-cycle pulses
  always_ff @(posedge clk) begin
    if (!rst) begin
      buffer        <= '0;
      count         <= '0;
      passcode      <= RESET_CODE;
      attempt_cnt   <= '0;
      relock_timer  <= '0;
      lockout_timer <= '0;
      fail_pulse    <= 1'b0;
      code_written  <= 1'b0;
    end else begin
      fail_pulse   <= 1'b0;
      code_written <= 1'b0;
      case (state)
        S_ENTRY, S_PROGRAM: begin
          if (do_clear) begin
            buffer <= '0;
            count  <= '0;
          end else if (state == S_PROGRAM && do_enter && buf_full) begin
            // Commit the new code and wipe it from the display buffer
            passcode     <= buffer;
            code_written <= 1'b1;
            relock_timer <= '0;
            buffer       <= '0;
            count        <= '0;
          end else if (do_key) begin
            buffer <= (buffer << 4) | W'(key_code);
            count  <= count + 4'd1;
          end
        end
        S_CHECK: begin
          buffer <= '0;
          count  <= '0;
          if (match) begin
            attempt_cnt  <= '0;
            relock_timer <= '0;
          end else begin
            fail_pulse  <= 1'b1;
            attempt_cnt <= attempts_inc;
            if (attempts_inc == MAX_ATT) lockout_timer <= LOCK_LOAD;
          end
        end
        S_UNLOCKED: begin
          if (lock_cmd || relock_expire) begin
            relock_timer <= '0;
          end else begin
            relock_timer <= relock_timer + TW'(1);
            if (program_en) begin
              buffer <= '0;
              count  <= '0;
            end
          end
        end
        S_ALARM: begin
          // Counter saturates at zero; an early acknowledge is simply lost
          if (!lockout_done)    lockout_timer <= lockout_timer - TW'(1);
          else if (alarm_reset) attempt_cnt   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign entry_digits = buffer;
  assign entry_count  = count;
  assign attempts     = attempt_cnt;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// tb/tb_keypad_lock_ctrl.sv - self-checking bench for keypad_lock_ctrl
module tb_keypad_lock_ctrl;

  localparam int          DIG   = 4;
  localparam logic [15:0] DEF   = 16'h1234;
  localparam int          MAXA  = 3;
  localparam int          LOCKC = 8;
  localparam int          RELC  = 16;

  localparam int M_ENTRY = 0;
  localparam int M_CHECK = 1;
  localparam int M_UNLK  = 2;
  localparam int M_PROG  = 3;
  localparam int M_ALARM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        enter_key = 1'b0;
  logic        clear_key = 1'b0;
  logic        lock_cmd = 1'b0;
  logic        program_en = 1'b0;
  logic        alarm_reset = 1'b0;
  logic        unlocked;
  logic        alarm;
  logic        programming;
  logic [15:0] entry_digits;
  logic [3:0]  entry_count;
  logic [3:0]  attempts;
  logic        fail_pulse;
  logic        code_written;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  // Reference model: lock mode, entered digits as a list, stored code, counters
  int          m_mode = M_ENTRY;
  int          m_entry[$];
  logic [15:0] m_code = DEF;
  int          m_att = 0;
  int          m_unlk_cycles = 0;
  int          m_alarm_cycles = 0;
  bit          m_fail = 1'b0;
  bit          m_cw = 1'b0;

  keypad_lock_ctrl #(
    .DIGITS(DIG), .DEFAULT_CODE(32'(DEF)), .MAX_ATTEMPTS(MAXA),
    .LOCKOUT_CYCLES(LOCKC), .RELOCK_CYCLES(RELC)
  ) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .enter_key(enter_key), .clear_key(clear_key), .lock_cmd(lock_cmd),
    .program_en(program_en), .alarm_reset(alarm_reset), .unlocked(unlocked),
    .alarm(alarm), .programming(programming), .entry_digits(entry_digits),
    .entry_count(entry_count), .attempts(attempts), .fail_pulse(fail_pulse),
    .code_written(code_written)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pack_entry();
    int v = 0;
    foreach (m_entry[i]) v = v * 16 + m_entry[i];
    return 16'(v);
  endfunction

  function automatic void model_step();
    m_fail = 1'b0;
    m_cw   = 1'b0;
    if (!rst) begin
      m_mode = M_ENTRY; m_code = DEF; m_entry.delete();
      m_att = 0; m_unlk_cycles = 0; m_alarm_cycles = 0;
      return;
    end
    case (m_mode)
      M_ENTRY, M_PROG: begin
        if (clear_key) begin
          m_entry.delete();
          if (m_mode == M_PROG) m_mode = M_UNLK;
        end else if (enter_key) begin
          if (m_mode == M_ENTRY && m_entry.size() > 0) m_mode = M_CHECK;
          else if (m_mode == M_PROG && m_entry.size() == DIG) begin
            m_code = pack_entry(); m_entry.delete(); m_cw = 1'b1;
            m_unlk_cycles = 0; m_mode = M_UNLK;
          end
        end else if (key_valid && key_code <= 4'd9 && m_entry.size() < DIG) begin
          m_entry.push_back(int'(key_code));
        end
      end
      M_CHECK: begin
        if (m_entry.size() == DIG && pack_entry() == m_code) begin
          m_mode = M_UNLK; m_att = 0; m_unlk_cycles = 0;
        end else begin
          m_fail = 1'b1;
          m_att++;
          if (m_att == MAXA) begin
            m_mode = M_ALARM; m_alarm_cycles = 0;
          end else begin
            m_mode = M_ENTRY;
          end
        end
        m_entry.delete();
      end
      M_UNLK: begin
        m_unlk_cycles++;
        if (lock_cmd || m_unlk_cycles == RELC) begin
          m_mode = M_ENTRY; m_unlk_cycles = 0;
        end else if (program_en) begin
          m_mode = M_PROG; m_entry.delete();
        end
      end
      M_ALARM: begin
        m_alarm_cycles++;
        if (alarm_reset && m_alarm_cycles >= LOCKC) begin
          m_mode = M_ENTRY; m_att = 0;
        end
      end
      default: m_mode = M_ENTRY;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("unlocked",     32'(unlocked),     32'(m_mode == M_UNLK || m_mode == M_PROG));
    chk("alarm",        32'(alarm),        32'(m_mode == M_ALARM));
    chk("programming",  32'(programming),  32'(m_mode == M_PROG));
    chk("entry_digits", 32'(entry_digits), 32'(pack_entry()));
    chk("entry_count",  32'(entry_count),  32'(m_entry.size()));
    chk("attempts",     32'(attempts),     32'(m_att));
    chk("fail_pulse",   32'(fail_pulse),   32'(m_fail));
    chk("code_written", 32'(code_written), 32'(m_cw));
  endtask

  task automatic step(input logic kv, input logic [3:0] kc, input logic en, input logic cl,
                      input logic lk, input logic pe, input logic ar);
    key_valid = kv; key_code = kc; enter_key = en; clear_key = cl;
    lock_cmd = lk; program_en = pe; alarm_reset = ar;
    @(posedge clk);
    model_step();
    #1;
    key_valid = 1'b0; key_code = 4'd0; enter_key = 1'b0; clear_key = 1'b0;
    lock_cmd = 1'b0; program_en = 1'b0; alarm_reset = 1'b0;
    check_model();
  endtask

  task automatic idle();           step(0, 4'd0, 0, 0, 0, 0, 0); endtask
  task automatic press(input logic [3:0] d); step(1, d, 0, 0, 0, 0, 0); endtask
  task automatic enter();          step(0, 4'd0, 1, 0, 0, 0, 0); endtask
  task automatic clear();          step(0, 4'd0, 0, 1, 0, 0, 0); endtask
  task automatic lock();           step(0, 4'd0, 0, 0, 1, 0, 0); endtask
  task automatic prog();           step(0, 4'd0, 0, 0, 0, 1, 0); endtask
  task automatic ack();            step(0, 4'd0, 0, 0, 0, 0, 1); endtask
  task automatic do_rst();
    rst = 1'b0; idle(); rst = 1'b1;
  endtask
  task automatic type_code(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) press(4'(c >> (4 * i)));
  endtask
  task automatic try_code(input logic [15:0] c);
    type_code(c); enter(); idle();
  endtask

  initial begin
    // Reset state
    do_rst();
    chk("rst_unlocked", 32'(unlocked), 32'd0);
    chk("rst_count",    32'(entry_count), 32'd0);

    // Correct code unlocks two edges after enter
    type_code(16'h1234);
    chk("t1_digits", 32'(entry_digits), 32'h1234);
    chk("t1_count",  32'(entry_count), 32'd4);
    enter();
    chk("t1_unl_k",  32'(unlocked), 32'd0);
    idle();
    chk("t1_unl_k1", 32'(unlocked), 32'd1);
    chk("t1_att",    32'(attempts), 32'd0);
    lock();
    chk("t1_lock",   32'(unlocked), 32'd0);

    // Three failures, early acknowledge lost, late acknowledge honoured
    try_code(16'h1235);
    chk("t2_fail1", 32'(fail_pulse), 32'd1);
    chk("t2_att1",  32'(attempts), 32'd1);
    press(4'd9); enter(); idle();
    chk("t2_fail2", 32'(fail_pulse), 32'd1);
    chk("t2_att2",  32'(attempts), 32'd2);
    try_code(16'h0000);
    chk("t2_fail3", 32'(fail_pulse), 32'd1);
    chk("t2_alarm", 32'(alarm), 32'd1);
    idle(); idle(); ack();
    chk("t2_early_ack", 32'(alarm), 32'd1);
    for (int i = 0; i < 4; i++) idle();
    ack();
    chk("t2_ack_alarm", 32'(alarm), 32'd0);
    chk("t2_ack_att",   32'(attempts), 32'd0);

    // Overflow key, non-BCD key, key+enter collision
    press(4'd1); press(4'hA); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    chk("t3_digits", 32'(entry_digits), 32'h1234);
    chk("t3_count",  32'(entry_count), 32'd4);
    step(1, 4'd7, 1, 0, 0, 0, 0);
    chk("t3_count_collide", 32'(entry_count), 32'd4);
    idle();
    chk("t3_unl", 32'(unlocked), 32'd1);

    // Reprogram to 9876
    prog();
    chk("t4_prog", 32'(programming), 32'd1);
    type_code(16'h9876); enter();
    chk("t4_cw",  32'(code_written), 32'd1);
    chk("t4_unl", 32'(unlocked), 32'd1);
    idle();
    chk("t4_cw_pulse", 32'(code_written), 32'd0);
    lock();
    try_code(16'h1234);
    chk("t4_old_fails", 32'(fail_pulse), 32'd1);
    try_code(16'h9876);
    chk("t4_new_unl", 32'(unlocked), 32'd1);

    // Auto-relock and program abort
    do_rst();
    try_code(16'h1234);
    for (int i = 0; i < 15; i++) idle();
    chk("t5_unl_15", 32'(unlocked), 32'd1);
    idle();
    chk("t5_relock", 32'(unlocked), 32'd0);
    try_code(16'h1234);
    prog(); press(4'd5); press(4'd5); press(4'd5); press(4'd5); clear();
    chk("t5_abort_prog", 32'(programming), 32'd0);
    chk("t5_abort_unl",  32'(unlocked), 32'd1);
    lock();
    try_code(16'h1234);
    chk("t5_code_kept", 32'(unlocked), 32'd1);
    lock();

    // Reset mid-ALARM and mid-PROGRAM
    try_code(16'h1111); try_code(16'h2222); try_code(16'h3333);
    chk("t6_in_alarm", 32'(alarm), 32'd1);
    do_rst();
    chk("t6_alarm_rst", 32'(alarm), 32'd0);
    chk("t6_att_rst",   32'(attempts), 32'd0);
    try_code(16'h1234);
    prog(); press(4'd7); press(4'd7);
    do_rst();
    chk("t6_prog_rst",  32'(programming), 32'd0);
    chk("t6_count_rst", 32'(entry_count), 32'd0);
    try_code(16'h1234);
    chk("t6_code_rst", 32'(unlocked), 32'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] kc;
      int p;
      p  = m_entry.size();
      kc = ($urandom_range(0, 1) == 1 && p < DIG) ? 4'(m_code >> (4 * (DIG - 1 - p)))
                                                   : 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 199) != 0);
      step(($urandom_range(0, 99) < 45), kc,
           ($urandom_range(0, 99) < 12), ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 99) < 3),  ($urandom_range(0, 99) < 6),
           ($urandom_range(0, 99) < 15));
      rst = 1'b1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
